// File: rtl/video_ddr_pkg.sv
// Shared definitions for the video-to-DDR write path.
// Holds the default pixel/slot/word geometry and the burst-count width.
// The ppw() helper gives the number of pixel slots per output word.
package video_ddr_pkg;

  localparam int AXI_W_DEF       = 128;
  localparam int PIX_W_DEF       = 24;
  localparam int SLOT_W_DEF      = 32;
  localparam int BURST_WORDS_DEF = 16;
  localparam int LINE_CNT_W_DEF  = 12;
  localparam int BURST_CNT_W     = 8;

  typedef logic [BURST_CNT_W-1:0] burst_cnt_t;

  function automatic int ppw(input int axi_w, input int slot_w);
    return axi_w / slot_w;
  endfunction

endpackage

// File: rtl/video_burst_packer_if.sv
// Write-side bus of the burst packer: packed-word FIFO write port plus the
// burst request handshake towards the AXI write master.
//   master : packer side (drives fifo_data_out/fifo_enable/burst_valid/burst_words)
//   slave  : FIFO / AXI master side (drives fifo_full/burst_ready)
interface video_burst_packer_if
  import video_ddr_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = AXI_W_DEF
);

  logic [AXI4_DATA_WIDTH-1:0] fifo_data_out;
  logic                       fifo_enable;
  logic                       fifo_full;
  logic                       burst_valid;
  logic                       burst_ready;
  burst_cnt_t                 burst_words;

  modport master (
    output fifo_data_out, fifo_enable, burst_valid, burst_words,
    input  fifo_full, burst_ready
  );

  modport slave (
    input  fifo_data_out, fifo_enable, burst_valid, burst_words,
    output fifo_full, burst_ready
  );

endinterface

// File: rtl/video_burst_req_gen.sv
// Burst request generator.
// Tracks words written since the last accepted request and raises a request
// either when BURST_WORDS are waiting or, after a line end, for the remainder.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   wr_en          one word written to the FIFO this cycle
//   line_end       line finished (sets the line-end pending flag)
//   frame_restart  frame start: drops a pending line-end flush
//   burst_ready    request accepted when burst_valid & burst_ready
//   burst_valid    request outstanding
//   burst_words    words in the outstanding request (frozen while valid)
module video_burst_req_gen
  import video_ddr_pkg::*;
#(
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       line_end,
  input  logic       frame_restart,
  input  logic       burst_ready,
  output logic       burst_valid,
  output burst_cnt_t burst_words
);

  localparam burst_cnt_t BW = BURST_CNT_W'(BURST_WORDS);

  burst_cnt_t pending_q, pending_d;
  burst_cnt_t words_q, words_d;
  logic       valid_q, valid_d;
  logic       lep_q, lep_d;
  logic       accept;

  always_comb begin
    valid_d   = valid_q;
    words_d   = words_q;
    lep_d     = lep_q;
    accept    = valid_q & burst_ready;
    // Write and accept in the same cycle net out.
    pending_d = pending_q + burst_cnt_t'(wr_en) - (accept ? words_q : '0);
    if (accept) valid_d = 1'b0;
    if (!valid_q) begin
      if (pending_q >= BW) begin
        // Threshold wins; a pending line-end flush waits for the next idle cycle.
        valid_d = 1'b1;
        words_d = BW;
      end else if (lep_q) begin
        if (pending_q != '0) begin
          valid_d = 1'b1;
          words_d = pending_q;
        end
        lep_d = 1'b0;
      end
    end
    if (line_end) lep_d = 1'b1;
    if (frame_restart) lep_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      words_q   <= '0;
      valid_q   <= 1'b0;
      lep_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      words_q   <= words_d;
      valid_q   <= valid_d;
      lep_q     <= lep_d;
    end
  end

  assign burst_valid = valid_q;
  assign burst_words = words_q;

endmodule

// File: rtl/video_burst_packer.sv
// Video burst packer: packs {fill, pixel} slots into AXI4_DATA_WIDTH words for
// the write FIFO (first pixel in the MSBs) and requests bursts from the AXI
// write master every BURST_WORDS words or at line end.
// Ports:
//   video_clk, video_rst_n   clock, async active-low reset
//   video_vs, video_de       vsync (rising edge starts a frame), pixel valid
//   video_data, fill_byte    pixel and fill bits placed above it in each slot
//   bus (master)             FIFO write port + burst request handshake
//   frame_start              1-cycle pulse after a vsync rising edge
//   line_cnt                 lines completed in the current frame (saturating)
//   err_overflow, err_clr    sticky dropped-word flag and its clear
// Build option: VIDEO_PACK_PARTIAL_FLUSH_EN writes a left-aligned, zero-padded
// partial word at line end; without it pixels pack continuously across lines.
module video_burst_packer
  import video_ddr_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = AXI_W_DEF,
  parameter int PIX_W           = PIX_W_DEF,
  parameter int SLOT_W          = SLOT_W_DEF,
  parameter int BURST_WORDS     = BURST_WORDS_DEF,
  parameter int LINE_CNT_W      = LINE_CNT_W_DEF
) (
  input  logic                  video_clk,
  input  logic                  video_rst_n,
  input  logic                  video_vs,
  input  logic                  video_de,
  input  logic [PIX_W-1:0]      video_data,
  input  logic [7:0]            fill_byte,
  video_burst_packer_if.master  bus,
  output logic                  frame_start,
  output logic [LINE_CNT_W-1:0] line_cnt,
  output logic                  err_overflow,
  input  logic                  err_clr
);

  localparam int PPW    = ppw(AXI4_DATA_WIDTH, SLOT_W);
  localparam int CNT_W  = $clog2(PPW + 1);
  localparam int FILL_W = SLOT_W - PIX_W;

  function automatic logic [LINE_CNT_W-1:0] sat_inc(input logic [LINE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                       de_d1_q, vs_d1_q;
  logic [CNT_W-1:0]           pix_cnt_q, pix_cnt_d, cnt_eff;
  logic [AXI4_DATA_WIDTH-1:0] word_q, word_d, data_q, data_d;
  logic                       wr_en_q, wr_en_d;
  logic                       err_q, err_d;
  logic                       frame_start_q;
  logic [LINE_CNT_W-1:0]      line_cnt_q, line_cnt_d;
  logic [SLOT_W-1:0]          slot;
  logic                       vs_rise, line_end, word_done, req_line_end;
  logic                       req_valid;
  burst_cnt_t                 req_words;

  assign slot     = {fill_byte[FILL_W-1:0], video_data};
  assign vs_rise  = video_vs & ~vs_d1_q;
  assign line_end = de_d1_q & ~video_de;

  always_comb begin
    // A vsync edge restarts packing; a pixel in that same cycle is slot 0.
    cnt_eff    = vs_rise ? '0 : pix_cnt_q;
    pix_cnt_d  = cnt_eff;
    word_d     = word_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    word_done  = 1'b0;
    err_d      = err_clr ? 1'b0 : err_q;
    line_cnt_d = vs_rise ? '0 : (line_end ? sat_inc(line_cnt_q) : line_cnt_q);
    if (video_de) begin
      word_d = (word_q << SLOT_W) | AXI4_DATA_WIDTH'(slot);
      if (cnt_eff == CNT_W'(PPW - 1)) begin
        word_done = 1'b1;
        pix_cnt_d = '0;
      end else begin
        pix_cnt_d = cnt_eff + 1'b1;
      end
    end
`ifdef VIDEO_PACK_PARTIAL_FLUSH_EN
    else if (line_end && cnt_eff != '0) begin
      // Older slots sit above the cnt_eff newest ones; shifting them out leaves
      // the partial line left-aligned with zeroed LSB slots.
      word_d    = word_q << ((PPW - int'(cnt_eff)) * SLOT_W);
      word_done = 1'b1;
      pix_cnt_d = '0;
    end
`endif
    // A full FIFO on the completing cycle drops the word; overflow beats err_clr.
    if (word_done) begin
      if (bus.fifo_full) begin
        err_d = 1'b1;
      end else begin
        wr_en_d = 1'b1;
        data_d  = word_d;
      end
    end
  end

`ifdef VIDEO_PACK_PARTIAL_FLUSH_EN
  // Line-end request is delayed one cycle so it counts the flushed word.
  logic line_end_dly_q;
  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) line_end_dly_q <= 1'b0;
    else              line_end_dly_q <= line_end & ~vs_rise;
  end
  assign req_line_end = line_end_dly_q;
`else
  assign req_line_end = line_end;
`endif

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      de_d1_q       <= 1'b0;
      vs_d1_q       <= 1'b0;
      pix_cnt_q     <= '0;
      word_q        <= '0;
      data_q        <= '0;
      wr_en_q       <= 1'b0;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
      line_cnt_q    <= '0;
    end else begin
      de_d1_q       <= video_de;
      vs_d1_q       <= video_vs;
      pix_cnt_q     <= pix_cnt_d;
      word_q        <= word_d;
      data_q        <= data_d;
      wr_en_q       <= wr_en_d;
      err_q         <= err_d;
      frame_start_q <= vs_rise;
      line_cnt_q    <= line_cnt_d;
    end
  end

  video_burst_req_gen #(
    .BURST_WORDS (BURST_WORDS)
  ) u_req_gen (
    .clk           (video_clk),
    .rst_n         (video_rst_n),
    .wr_en         (wr_en_q),
    .line_end      (req_line_end),
    .frame_restart (vs_rise),
    .burst_ready   (bus.burst_ready),
    .burst_valid   (req_valid),
    .burst_words   (req_words)
  );

  assign bus.fifo_data_out = data_q;
  assign bus.fifo_enable   = wr_en_q;
  assign bus.burst_valid   = req_valid;
  assign bus.burst_words   = req_words;
  assign frame_start       = frame_start_q;
  assign line_cnt          = line_cnt_q;
  assign err_overflow      = err_q;

endmodule
